// File: rtl/ddc_lanes.sv
// Multi-lane digital down-converter: LANES complex samples per clock are mixed by one
// internal NCO and summed into one complex output with a fixed 4+log2(LANES) latency.

module ddc_lane #(
  parameter int DIN_W   = 14,
  parameter int PHASE_W = 20,
  parameter int LUT_AW  = 10,
  parameter int LUT_DW  = 16,
  parameter int K       = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [3:0]                       en_i,
  input  logic [PHASE_W-1:0]               base_i,
  input  logic [PHASE_W-1:0]               pinc_i,
  input  logic [2*DIN_W-1:0]               din_i,
  input  logic [2**LUT_AW-1:0][LUT_DW-1:0] cos_tab_i,
  input  logic [2**LUT_AW-1:0][LUT_DW-1:0] sin_tab_i,
  output logic [DIN_W+LUT_DW:0]            ik_o,
  output logic [DIN_W+LUT_DW:0]            qk_o
);
  localparam int MW = DIN_W + LUT_DW;
  localparam int PW = MW + 1;

  logic        [PHASE_W-1:0] ph_q, ph_d;
  logic        [2*DIN_W-1:0] d1_q, d2_q;
  logic signed [LUT_DW-1:0]  cos_q, sin_q;
  logic signed [DIN_W-1:0]   i2, q2;
  logic        [LUT_AW-1:0]  addr;
  logic signed [MW-1:0]      ic_q, qs_q, qc_q, is_q;
  logic signed [MW-1:0]      ic_d, qs_d, qc_d, is_d;
  logic signed [PW-1:0]      ik_q, qk_q, ik_d, qk_d;

  // lane k sits k samples later in time than lane 0 within the same clock
  assign ph_d = base_i + PHASE_W'(K) * pinc_i;
  assign addr = ph_q[PHASE_W-1 -: LUT_AW];
  assign i2   = d2_q[DIN_W-1:0];
  assign q2   = d2_q[2*DIN_W-1:DIN_W];

  assign ic_d = MW'(i2) * MW'(cos_q);
  assign qs_d = MW'(q2) * MW'(sin_q);
  assign qc_d = MW'(q2) * MW'(cos_q);
  assign is_d = MW'(i2) * MW'(sin_q);

  // multiply by e^(-j*phase)
  assign ik_d = PW'(ic_q) + PW'(qs_q);
  assign qk_d = PW'(qc_q) - PW'(is_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      ph_q  <= '0;
      d1_q  <= '0;
      d2_q  <= '0;
      cos_q <= '0;
      sin_q <= '0;
      ic_q  <= '0;
      qs_q  <= '0;
      qc_q  <= '0;
      is_q  <= '0;
      ik_q  <= '0;
      qk_q  <= '0;
    end else begin
      if (en_i[0]) begin
        ph_q <= ph_d;
        d1_q <= din_i;
      end
      if (en_i[1]) begin
        cos_q <= cos_tab_i[addr];
        sin_q <= sin_tab_i[addr];
        d2_q  <= d1_q;
      end
      if (en_i[2]) begin
        ic_q <= ic_d;
        qs_q <= qs_d;
        qc_q <= qc_d;
        is_q <= is_d;
      end
      if (en_i[3]) begin
        ik_q <= ik_d;
        qk_q <= qk_d;
      end
    end
  end

  assign ik_o = ik_q;
  assign qk_o = qk_q;
endmodule

module ddc_lanes #(
  parameter int LANES      = 4,
  parameter int DIN_W      = 14,
  parameter int PHASE_W    = 20,
  parameter int LUT_AW     = 10,
  parameter int LUT_DW     = 16,
  parameter int LOG2_LANES = $clog2(LANES),
  parameter int OUT_W      = DIN_W + LUT_DW + 1 + LOG2_LANES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LANES*2*DIN_W-1:0] data_in,
  input  logic                     s_valid,
  input  logic [PHASE_W-1:0]       pinc,
  input  logic [PHASE_W-1:0]       poff,
  input  logic                     p_valid,
  input  logic                     resync,
  output logic                     configured,
  output logic                     valid_out,
  output logic [OUT_W-1:0]         i_out,
  output logic [OUT_W-1:0]         q_out
);
  localparam int  PW    = DIN_W + LUT_DW + 1;
  localparam int  LAT   = 4 + LOG2_LANES;
  localparam int  DEPTH = 2**LUT_AW;
  localparam real PI    = 3.14159265358979323846;
  localparam real AMP   = real'(2**(LUT_DW-1) - 1);

  // round half away from zero
  function automatic logic [LUT_DW-1:0] lut_rnd(input real x);
    int r;
    r = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    return LUT_DW'(r);
  endfunction

  logic [DEPTH-1:0][LUT_DW-1:0] cos_tab, sin_tab;

  for (genvar a = 0; a < DEPTH; a++) begin : g_lut
    localparam real ANG = 2.0 * PI * real'(a) / real'(DEPTH);
    localparam logic [LUT_DW-1:0] CV = lut_rnd(AMP * $cos(ANG));
    localparam logic [LUT_DW-1:0] SV = lut_rnd(AMP * $sin(ANG));
    assign cos_tab[a] = CV;
    assign sin_tab[a] = SV;
  end

  logic [PHASE_W-1:0] pinc_q, poff_q, acc_q, acc_d, acc_eff, base;
  logic               cfg_q, accept;
  logic [LAT:1]       vld_pipe_q;
  logic [LAT-1:0]     vld;

  assign accept  = s_valid && cfg_q && !rst;
  assign acc_eff = resync ? '0 : acc_q;
  assign acc_d   = accept ? acc_eff + PHASE_W'(LANES) * pinc_q : acc_eff;
  assign base    = acc_eff + poff_q;
  assign vld     = {vld_pipe_q[LAT-1:1], accept};

  // a sample accepted in the p_valid cycle still sees the old pinc/poff
  always_ff @(posedge clk) begin
    if (rst) begin
      pinc_q     <= '0;
      poff_q     <= '0;
      acc_q      <= '0;
      cfg_q      <= 1'b0;
      vld_pipe_q <= '0;
    end else begin
      acc_q      <= acc_d;
      vld_pipe_q <= vld;
      if (p_valid) begin
        pinc_q <= pinc;
        poff_q <= poff;
        cfg_q  <= 1'b1;
      end
    end
  end

  logic [LANES-1:0][PW-1:0] lane_i, lane_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    ddc_lane #(
      .DIN_W   (DIN_W),
      .PHASE_W (PHASE_W),
      .LUT_AW  (LUT_AW),
      .LUT_DW  (LUT_DW),
      .K       (k)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .en_i      (vld[3:0]),
      .base_i    (base),
      .pinc_i    (pinc_q),
      .din_i     (data_in[2*DIN_W*k +: 2*DIN_W]),
      .cos_tab_i (cos_tab),
      .sin_tab_i (sin_tab),
      .ik_o      (lane_i[k]),
      .qk_o      (lane_q[k])
    );
  end

  // level 0 is the sign-extended lane outputs; each further level is one registered stage
  for (genvar l = 0; l <= LOG2_LANES; l++) begin : g_lvl
    localparam int N = LANES >> l;
    logic signed [OUT_W-1:0] si [N];
    logic signed [OUT_W-1:0] sq [N];
    if (l == 0) begin : g_leaf
      for (genvar j = 0; j < N; j++) begin : g_j
        assign si[j] = OUT_W'($signed(lane_i[j]));
        assign sq[j] = OUT_W'($signed(lane_q[j]));
      end
    end else begin : g_add
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int j = 0; j < N; j++) begin
            si[j] <= '0;
            sq[j] <= '0;
          end
        end else if (vld[3+l]) begin
          for (int j = 0; j < N; j++) begin
            si[j] <= g_lvl[l-1].si[2*j] + g_lvl[l-1].si[2*j+1];
            sq[j] <= g_lvl[l-1].sq[2*j] + g_lvl[l-1].sq[2*j+1];
          end
        end
      end
    end
  end

  assign configured = cfg_q;
  assign valid_out  = vld_pipe_q[LAT];
  assign i_out      = g_lvl[LOG2_LANES].si[0];
  assign q_out      = g_lvl[LOG2_LANES].sq[0];
endmodule

// File: tb/tb_ddc_lanes.sv
// Directed bench for ddc_lanes: expected beats are pushed to a queue on accept and
// popped against valid_out, with the beat's arrival cycle checked as well.
module tb_ddc_lanes;
  localparam int LANES   = 4;
  localparam int DIN_W   = 14;
  localparam int PHASE_W = 20;
  localparam int LUT_AW  = 10;
  localparam int LUT_DW  = 16;
  localparam int LOG2_L  = 2;
  localparam int OUT_W   = DIN_W + LUT_DW + 1 + LOG2_L;
  localparam int LAT     = 4 + LOG2_L;
  localparam int DW      = LANES * 2 * DIN_W;

  logic               clk = 1'b0, rst = 1'b1, s_valid = 1'b0, p_valid = 1'b0, resync = 1'b0;
  logic [DW-1:0]      data_in = '0;
  logic [PHASE_W-1:0] pinc = '0, poff = '0;
  logic               configured, valid_out;
  logic [OUT_W-1:0]   i_out, q_out;

  ddc_lanes #(
    .LANES(LANES), .DIN_W(DIN_W), .PHASE_W(PHASE_W), .LUT_AW(LUT_AW), .LUT_DW(LUT_DW)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .s_valid(s_valid), .pinc(pinc), .poff(poff),
    .p_valid(p_valid), .resync(resync), .configured(configured), .valid_out(valid_out),
    .i_out(i_out), .q_out(q_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { longint i; longint q; int cyc; } exp_t;
  exp_t   sbq[$];
  exp_t   exp_rec[50];
  int     rec_idx = 0, rec_mode = 0;
  int     n_cmp = 0, n_bad = 0;
  bit     lit_mode = 0, hold_chk = 0;
  longint lit_i = 0, lit_q = 0, last_i = 0, last_q = 0;

  logic [PHASE_W-1:0] m_acc = '0, m_pinc = '0, m_poff = '0;
  bit                 m_cfg = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint so(input logic [OUT_W-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint lut(input int a, input bit sn);
    real ang, x;
    ang = 2.0 * 3.14159265358979323846 * real'(a) / real'(2**LUT_AW);
    x = real'(2**(LUT_DW-1) - 1) * (sn ? $sin(ang) : $cos(ang));
    return (x >= 0.0) ? longint'($rtoi(x + 0.5)) : -longint'($rtoi(0.5 - x));
  endfunction

  function automatic void mix(input logic [PHASE_W-1:0] ph0, input logic [PHASE_W-1:0] inc,
                              input logic [DW-1:0] din, output longint ei, output longint eq);
    logic [PHASE_W-1:0] ph;
    longint c, s, iv, qv;
    int a;
    ei = 0;
    eq = 0;
    for (int k = 0; k < LANES; k++) begin
      ph = ph0 + PHASE_W'(k) * inc;
      a  = int'(ph[PHASE_W-1 -: LUT_AW]);
      c  = lut(a, 1'b0);
      s  = lut(a, 1'b1);
      iv = longint'($signed(din[2*DIN_W*k +: DIN_W]));
      qv = longint'($signed(din[2*DIN_W*k+DIN_W +: DIN_W]));
      ei += iv * c + qv * s;
      eq += qv * c - iv * s;
    end
  endfunction

  function automatic logic [DW-1:0] fill(input int iv, input int qv);
    logic [DW-1:0] v;
    for (int k = 0; k < LANES; k++) begin
      v[2*DIN_W*k +: DIN_W]       = DIN_W'(iv);
      v[2*DIN_W*k+DIN_W +: DIN_W] = DIN_W'(qv);
    end
    return v;
  endfunction

  function automatic logic [DW-1:0] rnd_din();
    logic [DW-1:0] v;
    for (int k = 0; k < 2*LANES; k++) v[DIN_W*k +: DIN_W] = DIN_W'($urandom);
    return v;
  endfunction

  // Apply the behavioural model to the inputs present at the coming edge, then clock it.
  task automatic tick();
    logic [PHASE_W-1:0] acc_eff;
    exp_t e;
    bit acc;
    acc_eff = resync ? '0 : m_acc;
    acc     = s_valid && m_cfg && !rst;
    if (rst) begin
      m_acc = '0; m_pinc = '0; m_poff = '0; m_cfg = 0;
      sbq.delete();
    end else begin
      if (acc) begin
        if (lit_mode) begin
          e.i = lit_i; e.q = lit_q;
        end else if (rec_mode == 2 && rec_idx < 50) begin
          e.i = exp_rec[rec_idx].i; e.q = exp_rec[rec_idx].q; rec_idx++;
        end else begin
          mix(acc_eff + m_poff, m_pinc, data_in, e.i, e.q);
        end
        e.cyc = cyc + LAT;
        if (rec_mode == 1 && rec_idx < 50) begin
          exp_rec[rec_idx] = e; rec_idx++;
        end
        sbq.push_back(e);
      end
      m_acc = acc ? acc_eff + PHASE_W'(LANES) * m_pinc : acc_eff;
      if (p_valid) begin
        m_pinc = pinc; m_poff = poff; m_cfg = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    s_valid = 1'b0;
    repeat (LAT + 2) tick();
    chk(tag, sbq.size(), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (valid_out === 1'b1) begin
      if (sbq.size() == 0) chk("spurious_valid", longint'(valid_out), 0);
      else begin
        e = sbq.pop_front();
        chk("i_out", so(i_out), e.i);
        chk("q_out", so(q_out), e.q);
        chk("latency", cyc, e.cyc);
      end
    end else if (hold_chk) begin
      chk("hold_i", so(i_out), last_i);
      chk("hold_q", so(q_out), last_q);
    end
    last_i = so(i_out);
    last_q = so(q_out);
  end

  initial begin
    bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
    logic [DW-1:0] rec [50];

    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", longint'(valid_out), 0);
    chk("rst_i", so(i_out), 0);
    chk("rst_q", so(q_out), 0);
    chk("rst_cfg", longint'(configured), 0);

    // samples before and during the first p_valid are dropped
    data_in = fill(1000, 0);
    s_valid = 1'b1;
    tick();
    p_valid = 1'b1; pinc = '0; poff = '0;
    tick();
    p_valid = 1'b0;
    @(negedge clk);
    chk("cfg_set", longint'(configured), 1);
    lit_mode = 1; lit_i = 131068000; lit_q = 0;
    repeat (8) tick();

    s_valid = 1'b0; p_valid = 1'b1; poff = PHASE_W'(1 << 18);
    tick();
    p_valid = 1'b0; lit_i = 0; lit_q = -131068000; s_valid = 1'b1;
    repeat (8) tick();

    s_valid = 1'b0; p_valid = 1'b1; pinc = PHASE_W'(1 << 18); poff = '0;
    tick();
    p_valid = 1'b0; lit_i = 0; lit_q = 0; s_valid = 1'b1;
    repeat (8) tick();
    drain("drain_t123");
    lit_mode = 0;

    // random run, then replay after resync must reproduce the recorded expectations
    p_valid = 1'b1; resync = 1'b1; pinc = PHASE_W'(1234); poff = PHASE_W'(20'h0ABCD);
    tick();
    p_valid = 1'b0; resync = 1'b0;
    rec_mode = 1; rec_idx = 0;
    for (int n = 0; n < 50; n++) begin
      rec[n] = rnd_din(); data_in = rec[n]; s_valid = 1'b1;
      tick();
    end
    rec_mode = 0; s_valid = 1'b0;
    tick(); tick();
    rec_mode = 2; rec_idx = 0;
    for (int n = 0; n < 50; n++) begin
      data_in = rec[n]; resync = (n == 0); s_valid = 1'b1;
      tick();
    end
    resync = 1'b0; rec_mode = 0;
    drain("drain_t4");

    hold_chk = 1;
    for (int n = 0; n < 7; n++) begin
      data_in = rnd_din(); s_valid = pat[n]; resync = (n == 0);
      tick();
    end
    resync = 1'b0;
    drain("drain_t5");
    hold_chk = 0;

    for (int n = 0; n < 3; n++) begin
      data_in = rnd_din(); s_valid = 1'b1;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", longint'(valid_out), 0);
    chk("midrst_i", so(i_out), 0);
    chk("midrst_q", so(q_out), 0);
    chk("midrst_cfg", longint'(configured), 0);
    repeat (LAT + 3) begin
      data_in = rnd_din(); s_valid = 1'b1;
      tick();
    end
    @(negedge clk);
    chk("unconf_valid", longint'(valid_out), 0);
    chk("unconf_cfg", longint'(configured), 0);

    s_valid = 1'b0; p_valid = 1'b1; pinc = '0; poff = PHASE_W'(1 << 17);
    tick();
    p_valid = 1'b0;
    data_in = fill(-8192, -8192); s_valid = 1'b1;
    repeat (4) tick();
    drain("drain_t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
